fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Front-end producer for the instruction queue. Fetches two-word instruction pairs from instruction memory.
//  Consults the BTB/BHT on the fetch PC and redirects on predicted-taken branches and backend mispredicts.
//  Presents single or paired instructions to the queue's enqueue port, respecting iq_full and singlemode.
//  Sits between the imem/BTB and the instruction queue.
// PARAMETERS
//  RESET_PC   32'h0000_0000   first fetch address after reset
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous reset, active-high
//  imem_req       out  1   fetch request; held with imem_addr stable until imem_ack
//  imem_addr      out  32  fetch PC (bits[1:0]=0)
//  imem_ack       in   1   response valid; may assert in the same cycle as imem_req
//  imem_rdata     in   64  [31:0]=word@imem_addr, [63:32]=word@imem_addr+4
//  btb_hit        in   1   combinational BTB lookup on imem_addr
//  btb_target     in   32  BTB target for imem_addr
//  bht_taken      in   1   direction prediction for imem_addr
//  iq_full        in   1   queue has <2 free slots; no enqueue this cycle
//  singlemode     in   1   single-width operation
//  mispredict     in   1   backend flush
//  redirect_pc    in   32  restart PC, valid with mispredict (bits[1:0] ignored)
//  inst1_out_valid/inst1_out/inst1_out_pc4  out 1/32/32   slot-0 instruction and PC+4
//  inst2_out_valid/inst2_out/inst2_out_pc4  out 1/32/32   slot-1 instruction and PC+4
//  branch_valid   out  1   slot-0 carries BTB prediction; only asserted when inst2_out_valid=0
//  btb_pc_predict out  32  predicted next PC of slot-0 branch
//  direct_predict out  1   predicted direction of slot-0 branch
// BEHAVIOUR
//  State machine: S_IDLE -> S_REQ -> S_HOLD -> S_REQ ...; S_DRAIN on flush while a request is unacked.
//  - S_IDLE
//      * Entered on reset. imem_req=0. Next cycle -> S_REQ.
//  - S_REQ
//      * imem_req=1, imem_addr=pc.
//      * On imem_ack, capture the buffer: w0, w1, pc, hit, taken, target.
//      * If btb_hit: w1 is invalidated, and next pc = bht_taken ? btb_target : pc+4.
//      * Otherwise next pc = pc+8 (mod 2^32, wraps).
//      * On ack -> S_HOLD.
//  - S_HOLD
//      * Buffer valid. Outputs are combinational from the buffer, gated by !iq_full && !mispredict.
//      * Pair delivery: !singlemode, both words valid. Drives inst1+inst2, branch_valid=0, and empties the buffer.
//      * Single delivery: singlemode, or only w0 valid. Drives inst1 only. branch_valid=hit.
//        btb_pc_predict = taken ? target : pc+4. direct_predict = taken.
//        w1 shifts to slot 0 with pc+4, and hit is cleared.
//      * Buffer empty after delivery -> S_REQ in the next cycle. Minimum 2 cycles per fetch.
//  - Output values
//      * inst*_pc4 is the word address + 4.
//      * The btb fields hold 0 when branch_valid=0.
//  - mispredict (priority below rst, above everything else)
//      * pc <= {redirect_pc[31:2],2'b00} and the buffer is cleared.
//      * All out valids are 0 in that cycle.
//      * S_REQ without ack this cycle -> S_DRAIN. S_REQ with ack -> data discarded, then S_REQ.
//      * S_HOLD/S_IDLE -> S_REQ.
//  - S_DRAIN
//      * imem_req stays 1 on the old address until ack; the response is discarded.
//      * Then S_REQ at the redirect pc.
//      * A further mispredict in S_DRAIN updates pc only.
//  - rst
//      * state=S_IDLE, pc=RESET_PC, buffer cleared.
//      * All outputs 0: imem_req, all valids, branch_valid, direct_predict, btb_pc_predict.
//      * Applies mid-request; no drain on reset.
//  - iq_full held high in S_HOLD: the buffer is held indefinitely, with no new request.
//  - singlemode may change in any cycle; it is sampled in the delivery cycle.
// CONFIGURATION
//  FETCH_PERF_EN defined:
//      * Adds out ports perf_fetch_cnt[31:0] (imem acks accepted, excluding drained ones) and
//        perf_stall_cnt[31:0] (S_HOLD cycles with iq_full=1).
//      * Both counters clear on rst and wrap at 2^32.
//  FETCH_PERF_EN undefined: no ports, no counters; behaviour otherwise identical.
// TESTING
//  1. Reset then imem_ack 1 cycle after req, no BTB hits, iq_full=0
//     -> imem_addr sequence 0,8,16. Pairs delivered with inst1_out_pc4=4, inst2_out_pc4=8, then 12/16.
//  2. btb_hit=1, bht_taken=1, btb_target=0x100 at pc=0x20
//     -> single inst1 (pc4=0x24), branch_valid=1, btb_pc_predict=0x100, direct_predict=1.
//     -> inst2 invalid; next imem_addr=0x100.
//  3. singlemode=1, pair at 0x40 -> inst1 pc4=0x44 in cycle N, inst1 pc4=0x48 in cycle N+1.
//     -> inst2_out_valid=0 throughout.
//  4. iq_full=1 for 5 cycles in S_HOLD -> no valids, no imem_req; delivery in the cycle iq_full drops.
//     -> perf_stall_cnt=5 (FETCH_PERF_EN).
//  5. mispredict with redirect_pc=0x203 while a request is unacked
//     -> old addr held until ack, data discarded, next imem_addr=0x200; no valids meanwhile.
//  6. rst asserted in S_HOLD with iq_full=0
//     -> same cycle no enqueue. Next cycle imem_req=0; then imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: front-end producer for the instruction queue.
//
// Fetches 64-bit instruction pairs from instruction memory, consults the BTB/BHT on
// the fetch PC, and hands single or paired instructions to the queue's enqueue port.
// Backend mispredicts restart fetch at redirect_pc. A flush that lands while a memory
// request is still outstanding drains that response before the new fetch is issued.
//
// Optional feature (macro FETCH_PERF_EN): adds perf_fetch_cnt / perf_stall_cnt.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   imem_req/imem_addr            fetch request, address held stable until imem_ack
//   imem_ack/imem_rdata           response: [31:0] word@addr, [63:32] word@addr+4
//   btb_hit/btb_target/bht_taken  branch prediction lookup on imem_addr
//   iq_full                       queue cannot take an enqueue this cycle
//   singlemode                    deliver one instruction per cycle
//   mispredict/redirect_pc        backend flush and restart PC
//   inst1_out_*/inst2_out_*       slot-0 / slot-1 instruction, valid and PC+4
//   branch_valid/btb_pc_predict/direct_predict  slot-0 prediction (single delivery only)
//   perf_fetch_cnt/perf_stall_cnt accepted fetches / iq_full stall cycles (FETCH_PERF_EN)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [63:0] imem_rdata,
  input  logic        btb_hit,
  input  logic [31:0] btb_target,
  input  logic        bht_taken,
  input  logic        iq_full,
  input  logic        singlemode,
  input  logic        mispredict,
  input  logic [31:0] redirect_pc,
  output logic        inst1_out_valid,
  output logic [31:0] inst1_out,
  output logic [31:0] inst1_out_pc4,
  output logic        inst2_out_valid,
  output logic [31:0] inst2_out,
  output logic [31:0] inst2_out_pc4,
  output logic        branch_valid,
  output logic [31:0] btb_pc_predict,
  output logic        direct_predict
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DRAIN} state_t;

  localparam logic [31:0] WordMask = 32'hFFFF_FFFC;

  state_t      r_state;
  logic [31:0] r_pc;          // next fetch address (redirect target while draining)
  logic [31:0] r_drain_addr;  // address of the in-flight request being drained
  logic [31:0] r_w0;
  logic [31:0] r_w1;
  logic        r_v0;
  logic        r_v1;
  logic [31:0] r_bpc;         // word address of the instruction in slot 0
  logic        r_hit;
  logic        r_taken;
  logic [31:0] r_target;

  logic w_deliver;
  logic w_pair;
  logic w_single;
  logic w_empty_after;

  // Enqueue only from a valid buffer when the queue has room and no flush/reset is active.
  assign w_deliver = (r_state == S_HOLD) && r_v0 && !iq_full && !mispredict && !rst;
  assign w_pair    = w_deliver && !singlemode && r_v1;
  assign w_single  = w_deliver && !w_pair;
  // A single delivery with w1 still valid keeps the buffer; everything else empties it.
  assign w_empty_after = w_pair || !r_v1;

  always_comb begin
    imem_req        = !rst && ((r_state == S_REQ) || (r_state == S_DRAIN));
    imem_addr       = (r_state == S_DRAIN) ? r_drain_addr : r_pc;

    inst1_out_valid = w_deliver;
    inst1_out       = w_deliver ? r_w0 : 32'h0;
    inst1_out_pc4   = w_deliver ? r_bpc + 32'd4 : 32'h0;

    inst2_out_valid = w_pair;
    inst2_out       = w_pair ? r_w1 : 32'h0;
    inst2_out_pc4   = w_pair ? r_bpc + 32'd8 : 32'h0;

    // r_hit is only ever set with w1 invalidated, so this is always a single delivery.
    branch_valid    = w_single && r_hit;
    btb_pc_predict  = 32'h0;
    direct_predict  = 1'b0;
    if (branch_valid) begin
      btb_pc_predict = r_taken ? r_target : r_bpc + 32'd4;
      direct_predict = r_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_drain_addr <= 32'h0;
      r_w0         <= 32'h0;
      r_w1         <= 32'h0;
      r_v0         <= 1'b0;
      r_v1         <= 1'b0;
      r_bpc        <= 32'h0;
      r_hit        <= 1'b0;
      r_taken      <= 1'b0;
      r_target     <= 32'h0;
    end else if (mispredict) begin
      r_pc  <= redirect_pc & WordMask;
      r_v0  <= 1'b0;
      r_v1  <= 1'b0;
      r_hit <= 1'b0;
      unique case (r_state)
        S_REQ: begin
          // An unacked request must still complete on the bus; park it in S_DRAIN.
          if (imem_ack) begin
            r_state <= S_REQ;
          end else begin
            r_state      <= S_DRAIN;
            r_drain_addr <= r_pc;
          end
        end
        S_DRAIN: begin
          // Drain address is unchanged; only the restart PC moves.
          if (imem_ack) r_state <= S_REQ;
        end
        default: r_state <= S_REQ;
      endcase
    end else begin
      unique case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          if (imem_ack) begin
            r_w0     <= imem_rdata[31:0];
            r_w1     <= imem_rdata[63:32];
            r_v0     <= 1'b1;
            r_v1     <= !btb_hit;
            r_bpc    <= r_pc;
            r_hit    <= btb_hit;
            r_taken  <= bht_taken;
            r_target <= btb_target & WordMask;
            if (btb_hit) begin
              r_pc <= bht_taken ? (btb_target & WordMask) : r_pc + 32'd4;
            end else begin
              r_pc <= r_pc + 32'd8;
            end
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_deliver) begin
            if (w_empty_after) begin
              r_v0    <= 1'b0;
              r_v1    <= 1'b0;
              r_hit   <= 1'b0;
              r_state <= S_REQ;
            end else begin
              r_w0  <= r_w1;
              r_bpc <= r_bpc + 32'd4;
              r_v1  <= 1'b0;
              r_hit <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (imem_ack) r_state <= S_REQ;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= 32'h0;
      r_stall_cnt <= 32'h0;
    end else begin
      // Drained and flush-discarded responses are not counted.
      if ((r_state == S_REQ) && imem_ack && !mispredict) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if ((r_state == S_HOLD) && iq_full) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [63:0] imem_rdata;
  logic        btb_hit;
  logic [31:0] btb_target;
  logic        bht_taken;
  logic        iq_full;
  logic        singlemode;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        inst1_out_valid;
  logic [31:0] inst1_out;
  logic [31:0] inst1_out_pc4;
  logic        inst2_out_valid;
  logic [31:0] inst2_out;
  logic [31:0] inst2_out_pc4;
  logic        branch_valid;
  logic [31:0] btb_pc_predict;
  logic        direct_predict;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .btb_hit        (btb_hit),
    .btb_target     (btb_target),
    .bht_taken      (bht_taken),
    .iq_full        (iq_full),
    .singlemode     (singlemode),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .inst1_out_valid(inst1_out_valid),
    .inst1_out      (inst1_out),
    .inst1_out_pc4  (inst1_out_pc4),
    .inst2_out_valid(inst2_out_valid),
    .inst2_out      (inst2_out),
    .inst2_out_pc4  (inst2_out_pc4),
    .branch_valid   (branch_valid),
    .btb_pc_predict (btb_pc_predict),
    .direct_predict (direct_predict)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory contents: each word is tagged with its own address.
  function automatic logic [31:0] mw(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Two-cycle request: no ack in the first cycle, ack with data in the second.
  task automatic fetch(input logic [31:0] a, input logic hit, input logic taken,
                       input logic [31:0] tgt);
    imem_ack = 1'b0;
    #1;
    chk("req_wait", {63'h0, imem_req}, 64'h1);
    chk("addr_wait", {32'h0, imem_addr}, {32'h0, a});
    step();
    imem_ack   = 1'b1;
    imem_rdata = {mw(a + 32'd4), mw(a)};
    btb_hit    = hit;
    bht_taken  = taken;
    btb_target = tgt;
    #1;
    chk("addr_ack", {32'h0, imem_addr}, {32'h0, a});
    chk("nov_ack", {63'h0, inst1_out_valid}, 64'h0);
    step();
    imem_ack   = 1'b0;
    btb_hit    = 1'b0;
    bht_taken  = 1'b0;
    btb_target = 32'h0;
  endtask

  task automatic pair(input logic [31:0] a);
    #1;
    chk("pair_v1", {63'h0, inst1_out_valid}, 64'h1);
    chk("pair_i1", {32'h0, inst1_out}, {32'h0, mw(a)});
    chk("pair_pc1", {32'h0, inst1_out_pc4}, {32'h0, a + 32'd4});
    chk("pair_v2", {63'h0, inst2_out_valid}, 64'h1);
    chk("pair_i2", {32'h0, inst2_out}, {32'h0, mw(a + 32'd4)});
    chk("pair_pc2", {32'h0, inst2_out_pc4}, {32'h0, a + 32'd8});
    chk("pair_bv", {63'h0, branch_valid}, 64'h0);
    chk("pair_req", {63'h0, imem_req}, 64'h0);
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 64'h0; btb_hit = 1'b0; btb_target = 32'h0;
    bht_taken = 1'b0; iq_full = 1'b0; singlemode = 1'b0; mispredict = 1'b0;
    redirect_pc = 32'h0;
    step();
    step();
    #1;
    chk("rst_req", {63'h0, imem_req}, 64'h0);
    chk("rst_v1", {63'h0, inst1_out_valid}, 64'h0);
    chk("rst_bv", {63'h0, branch_valid}, 64'h0);
    chk("rst_pred", {32'h0, btb_pc_predict}, 64'h0);
    rst = 1'b0;
    #1;
    chk("idle_req", {63'h0, imem_req}, 64'h0);
    step();

    // Sequential pairs, no predictions.
    fetch(32'h0, 1'b0, 1'b0, 32'h0);   pair(32'h0);  step();
    fetch(32'h8, 1'b0, 1'b0, 32'h0);   pair(32'h8);  step();
    fetch(32'h10, 1'b0, 1'b0, 32'h0);  pair(32'h10); step();
    fetch(32'h18, 1'b0, 1'b0, 32'h0);  pair(32'h18); step();

    // Predicted-taken branch at 0x20.
    fetch(32'h20, 1'b1, 1'b1, 32'h100);
    #1;
    chk("br_v1", {63'h0, inst1_out_valid}, 64'h1);
    chk("br_pc4", {32'h0, inst1_out_pc4}, 64'h24);
    chk("br_v2", {63'h0, inst2_out_valid}, 64'h0);
    chk("br_bv", {63'h0, branch_valid}, 64'h1);
    chk("br_pred", {32'h0, btb_pc_predict}, 64'h100);
    chk("br_dir", {63'h0, direct_predict}, 64'h1);
    step();

    // Fetch at the target, then flush from S_HOLD to 0x40.
    fetch(32'h100, 1'b0, 1'b0, 32'h0);
    mispredict = 1'b1; redirect_pc = 32'h40;
    #1;
    chk("mph_v1", {63'h0, inst1_out_valid}, 64'h0);
    chk("mph_v2", {63'h0, inst2_out_valid}, 64'h0);
    step();
    mispredict = 1'b0;

    // Singlemode splits the pair over two cycles.
    fetch(32'h40, 1'b0, 1'b0, 32'h0);
    singlemode = 1'b1;
    #1;
    chk("sm0_v1", {63'h0, inst1_out_valid}, 64'h1);
    chk("sm0_i1", {32'h0, inst1_out}, {32'h0, mw(32'h40)});
    chk("sm0_pc4", {32'h0, inst1_out_pc4}, 64'h44);
    chk("sm0_v2", {63'h0, inst2_out_valid}, 64'h0);
    chk("sm0_req", {63'h0, imem_req}, 64'h0);
    step();
    #1;
    chk("sm1_v1", {63'h0, inst1_out_valid}, 64'h1);
    chk("sm1_i1", {32'h0, inst1_out}, {32'h0, mw(32'h44)});
    chk("sm1_pc4", {32'h0, inst1_out_pc4}, 64'h48);
    chk("sm1_v2", {63'h0, inst2_out_valid}, 64'h0);
    chk("sm1_bv", {63'h0, branch_valid}, 64'h0);
    step();
    singlemode = 1'b0;

    // Queue full for five cycles holds the buffer.
    fetch(32'h48, 1'b0, 1'b0, 32'h0);
    iq_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("full_v1", {63'h0, inst1_out_valid}, 64'h0);
      chk("full_req", {63'h0, imem_req}, 64'h0);
      step();
    end
    iq_full = 1'b0;
    pair(32'h48);
`ifdef FETCH_PERF_EN
    chk("perf_stall", {32'h0, perf_stall_cnt}, 64'd5);
    chk("perf_fetch", {32'h0, perf_fetch_cnt}, 64'd8);
`endif
    step();

    // Flush while the request at 0x50 is unacked: drain, then restart at 0x200.
    mispredict = 1'b1; redirect_pc = 32'h203;
    #1;
    chk("mpr_req", {63'h0, imem_req}, 64'h1);
    chk("mpr_addr", {32'h0, imem_addr}, 64'h50);
    chk("mpr_v1", {63'h0, inst1_out_valid}, 64'h0);
    step();
    mispredict = 1'b0;
    #1;
    chk("drn_req", {63'h0, imem_req}, 64'h1);
    chk("drn_addr", {32'h0, imem_addr}, 64'h50);
    step();
    imem_ack = 1'b1; imem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    chk("drn_ack_addr", {32'h0, imem_addr}, 64'h50);
    chk("drn_ack_v1", {63'h0, inst1_out_valid}, 64'h0);
    step();
    imem_ack = 1'b0;
    #1;
    chk("post_drn_v1", {63'h0, inst1_out_valid}, 64'h0);
    fetch(32'h200, 1'b0, 1'b0, 32'h0);
    pair(32'h200);
`ifdef FETCH_PERF_EN
    chk("perf_fetch_drn", {32'h0, perf_fetch_cnt}, 64'd9);
`endif
    step();

    // Reset in S_HOLD with the queue ready.
    fetch(32'h208, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    chk("rsth_v1", {63'h0, inst1_out_valid}, 64'h0);
    chk("rsth_v2", {63'h0, inst2_out_valid}, 64'h0);
    step();
    rst = 1'b0;
    #1;
    chk("rsti_req", {63'h0, imem_req}, 64'h0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_f", {32'h0, perf_fetch_cnt}, 64'd0);
    chk("rst_perf_s", {32'h0, perf_stall_cnt}, 64'd0);
`endif
    step();

    // BTB hit predicted not-taken at the reset PC.
    fetch(32'h0, 1'b1, 1'b0, 32'h300);
    #1;
    chk("nt_v1", {63'h0, inst1_out_valid}, 64'h1);
    chk("nt_pc4", {32'h0, inst1_out_pc4}, 64'h4);
    chk("nt_v2", {63'h0, inst2_out_valid}, 64'h0);
    chk("nt_bv", {63'h0, branch_valid}, 64'h1);
    chk("nt_pred", {32'h0, btb_pc_predict}, 64'h4);
    chk("nt_dir", {63'h0, direct_predict}, 64'h0);
    step();
    #1;
    chk("nt_next_req", {63'h0, imem_req}, 64'h1);
    chk("nt_next_addr", {32'h0, imem_addr}, 64'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
